// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one external adder among NUM_REQ requesters.
// Optional: define ADDER_ARB_STATS_EN to enable the ops_count counter.
module adder_arbiter #(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_A,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_B,
  output logic [DATA_WIDTH-1:0]         adder_A,
  output logic [DATA_WIDTH-1:0]         adder_B,
  input  logic [DATA_WIDTH:0]           adder_X,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [DATA_WIDTH:0]           resp_X,
  output logic [$clog2(NUM_REQ)-1:0]    resp_id,
  output logic [15:0]                   ops_count
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int IW1 = IDW + 1;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    RESP
  } state_t;

  state_t                state_q, state_d;
  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH:0]   x_q, x_d;
  logic [IDW-1:0]        id_q, id_d;

  logic                  gnt_found;
  logic [IDW-1:0]        gnt_idx;
  logic [NUM_REQ-1:0]    gnt_oh;
  logic [IW1-1:0]        idx_w;
  logic [IDW-1:0]        nxt_ptr;

  // Scan from rr_ptr upward with wrap; the first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_oh    = '0;
    idx_w     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_w = {1'b0, rr_ptr_q} + IW1'(k);
      if (idx_w >= IW1'(NUM_REQ))
        idx_w = idx_w - IW1'(NUM_REQ);
      if (!gnt_found && req_valid[idx_w[IDW-1:0]]) begin
        gnt_found                 = 1'b1;
        gnt_idx                   = idx_w[IDW-1:0];
        gnt_oh[idx_w[IDW-1:0]]    = 1'b1;
      end
    end
  end

  assign nxt_ptr = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    a_d       = a_q;
    b_d       = b_q;
    x_d       = x_q;
    id_d      = id_q;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          req_ready = gnt_oh;
          a_d       = req_A[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
          b_d       = req_B[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
          id_d      = gnt_idx;
          rr_ptr_d  = nxt_ptr;
          state_d   = ADD;
        end
      end
      ADD: begin
        x_d     = adder_X;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      x_q      <= '0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      x_q      <= x_d;
      id_q     <= id_d;
    end
  end

  assign adder_A    = a_q;
  assign adder_B    = b_q;
  assign resp_X     = x_q;
  assign resp_id    = id_q;
  assign resp_valid = (state_q == RESP);

`ifdef ADDER_ARB_STATS_EN
  logic [15:0] ops_q, ops_d;

  always_comb begin
    ops_d = ops_q;
    if (resp_valid && resp_ready && ops_q != 16'hFFFF)
      ops_d = ops_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ops_q <= '0;
    else
      ops_q <= ops_d;
  end

  assign ops_count = ops_q;
`else
  assign ops_count = '0;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized/directed bench for adder_arbiter with a transaction-level model.
module tb_adder_arbiter;

  localparam int DW = 4;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*DW-1:0] req_A, req_B;
  logic [DW-1:0] adder_A, adder_B;
  logic [DW:0]   adder_X;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW:0]   resp_X;
  logic [1:0]    resp_id;
  logic [15:0]   ops_count;

  adder_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_A(req_A), .req_B(req_B),
    .adder_A(adder_A), .adder_B(adder_B), .adder_X(adder_X),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_X(resp_X), .resp_id(resp_id), .ops_count(ops_count)
  );

  // External shared adder.
  assign adder_X = {1'b0, adder_A} + {1'b0, adder_B};

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: phase 0 waiting, 1 adding, 2 responding.
  int m_ptr, m_phase, m_id, m_sum, m_ops;
  int m_a, m_b;
  int last_x;
  int g_id[$];
  int g_cyc[$];

`ifdef ADDER_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_ops();
    return STATS ? m_ops : 0;
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_phase = 0;
    m_ops   = 0;
  endtask

  task automatic step(input logic [N-1:0] v, input logic rr,
                      input logic [15:0] a, input logic [15:0] b);
    logic [N-1:0] exp_rdy;
    int gi;
    @(negedge clk);
    req_valid  = v;
    resp_ready = rr;
    req_A      = a;
    req_B      = b;
    #1;
    cyc++;
    exp_rdy = '0;
    gi = -1;
    if (m_phase == 0)
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (gi < 0 && v[j]) gi = j;
      end
    if (gi >= 0) exp_rdy[gi] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("resp_valid", 32'(resp_valid), 32'(m_phase == 2));
    chk("ops_count", 32'(ops_count), 32'(exp_ops()));
    for (int i = 0; i < N; i++)
      if (req_ready[i] === 1'b1) begin
        g_id.push_back(i);
        g_cyc.push_back(cyc);
      end
    case (m_phase)
      0: if (gi >= 0) begin
        m_id    = gi;
        m_a     = int'(a[gi*DW +: DW]);
        m_b     = int'(b[gi*DW +: DW]);
        m_sum   = m_a + m_b;
        m_ptr   = (gi + 1) % N;
        m_phase = 1;
      end
      1: begin
        chk("adder_A", 32'(adder_A), 32'(m_a));
        chk("adder_B", 32'(adder_B), 32'(m_b));
        m_phase = 2;
      end
      default: begin
        chk("resp_X", 32'(resp_X), 32'(m_sum));
        chk("resp_id", 32'(resp_id), 32'(m_id));
        last_x = int'(resp_X);
        if (rr) begin
          if (m_ops < 65535) m_ops++;
          m_phase = 0;
        end
      end
    endcase
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_adder_A"}, 32'(adder_A), 32'd0);
    chk({tag, "_adder_B"}, 32'(adder_B), 32'd0);
    chk({tag, "_resp_X"}, 32'(resp_X), 32'd0);
    chk({tag, "_resp_id"}, 32'(resp_id), 32'd0);
    chk({tag, "_ops_count"}, 32'(ops_count), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    req_valid = '0;
    rst = 1'b1;
    #1;
    chk_reset_outs(tag);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b0;
    req_A      = '0;
    req_B      = '0;
    last_x     = 0;
    m_id = 0; m_sum = 0; m_a = 0; m_b = 0;
    model_reset();
    #1;
    chk_reset_outs("rst0");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single op: requester 0, 3+5.
    g_id.delete(); g_cyc.delete();
    step(4'b0001, 1'b1, 16'h0003, 16'h0005);
    step(4'b0000, 1'b1, 16'h0000, 16'h0000);
    step(4'b0000, 1'b1, 16'h0000, 16'h0000);
    chk("single_gid", 32'(g_id.size() > 0 ? g_id[0] : -1), 32'd0);
    chk("single_x", 32'(last_x), 32'd8);

    // Round robin from a fresh reset.
    do_reset("rst1");
    g_id.delete(); g_cyc.delete();
    for (int s = 0; s < 15; s++)
      step(4'b1111, 1'b1, 16'($urandom), 16'($urandom));
    chk("rr_count", 32'(g_id.size()), 32'd5);
    for (int i = 0; i < 5 && i < g_id.size(); i++) begin
      chk("rr_id", 32'(g_id[i]), 32'(i % 4));
      if (i > 0) chk("rr_gap", 32'(g_cyc[i] - g_cyc[i-1]), 32'd3);
    end

    // Widest sum: 15 + 15.
    for (int s = 0; s < 3; s++)
      step(4'b1000, 1'b1, 16'hFFFF, 16'hFFFF);
    chk("ovf_x", 32'(last_x), 32'd30);

    // Backpressure: 5 stalled RESP cycles.
    g_id.delete(); g_cyc.delete();
    for (int s = 0; s < 7; s++)
      step(4'b1111, 1'b0, 16'($urandom), 16'($urandom));
    step(4'b1111, 1'b1, 16'($urandom), 16'($urandom));
    step(4'b1111, 1'b1, 16'($urandom), 16'($urandom));
    chk("bp_count", 32'(g_id.size()), 32'd2);
    if (g_id.size() == 2) begin
      chk("bp_id0", 32'(g_id[0]), 32'd0);
      chk("bp_id1", 32'(g_id[1]), 32'd1);
      chk("bp_gap", 32'(g_cyc[1] - g_cyc[0]), 32'd8);
    end
    step(4'b0000, 1'b1, 16'h0, 16'h0);
    step(4'b0000, 1'b1, 16'h0, 16'h0);

    // Reset while in ADD discards the operation.
    step(4'b0001, 1'b1, 16'h0005, 16'h0006);
    do_reset("rst_mid");
    step(4'b0000, 1'b1, 16'h0, 16'h0);
    step(4'b0000, 1'b1, 16'h0, 16'h0);
    g_id.delete(); g_cyc.delete();
    step(4'b0100, 1'b1, 16'h0700, 16'h0200);
    chk("mid_gid", 32'(g_id.size() > 0 ? g_id[0] : -1), 32'd2);
    step(4'b0000, 1'b1, 16'h0, 16'h0);
    step(4'b0000, 1'b1, 16'h0, 16'h0);
    chk("mid_x", 32'(last_x), 32'd9);

    // Random traffic.
    for (int s = 0; s < 120; s++)
      step(4'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
    step(4'b0000, 1'b1, 16'h0, 16'h0);
    step(4'b0000, 1'b1, 16'h0, 16'h0);
    step(4'b0000, 1'b1, 16'h0, 16'h0);

    // Ten completed ops after reset.
    do_reset("rst_stats");
    for (int s = 0; s < 30; s++)
      step(4'b1111, 1'b1, 16'($urandom), 16'($urandom));
    step(4'b0000, 1'b1, 16'h0, 16'h0);
    chk("stats_ops", 32'(ops_count), STATS ? 32'd10 : 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, operand width of the shared adder.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester operation request.
REQ-006 SHALL have port req_ready  output  NUM_REQ  per-requester accept (one-hot or zero).
REQ-007 SHALL have port req_A  input  NUM_REQ*DATA_WIDTH  packed operand A; slice i belongs to requester i.
REQ-008 SHALL have port req_B  input  NUM_REQ*DATA_WIDTH  packed operand B; slice i belongs to requester i.
REQ-009 SHALL have port adder_A  output  DATA_WIDTH  operand A to the external shared adder, registered.
REQ-010 SHALL have port adder_B  output  DATA_WIDTH  operand B to the external shared adder, registered.
REQ-011 SHALL have port adder_X  input  DATA_WIDTH+1  unsigned sum from the external shared adder (combinational).
REQ-012 SHALL have port resp_valid  output  1  result available.
REQ-013 SHALL have port resp_ready  input  1  consumer accepts result.
REQ-014 SHALL have port resp_X  output  DATA_WIDTH+1  registered result.
REQ-015 SHALL have port resp_id  output  $clog2(NUM_REQ)  index of requester that owns resp_X.
REQ-016 SHALL have port ops_count  output  16  completed-operation counter (see Configuration).

Function
REQ-017 SHALL implement FSM states IDLE, ADD, RESP.
REQ-018 IDLE: SHALL assert req_ready for exactly one requester, the first valid one at or after rr_ptr in ascending wrap-around order; all req_ready low if no req_valid.
REQ-019 req_ready SHALL be low in ADD and RESP regardless of req_valid.
REQ-020 On req_valid[i]&req_ready[i] edge: SHALL latch slice i of req_A/req_B into adder_A/adder_B, latch i into resp_id, set rr_ptr to (i+1) mod NUM_REQ, go to ADD.
REQ-021 ADD: SHALL hold adder_A/adder_B stable and on the next edge capture adder_X into resp_X and go to RESP (exactly one cycle in ADD).
REQ-022 RESP: SHALL assert resp_valid with resp_X/resp_id stable until resp_valid&resp_ready edge, then go to IDLE.
REQ-023 Minimum request-to-request spacing SHALL be 3 cycles (accept, ADD, RESP with resp_ready high); resp_valid rises 2 edges after accept.
REQ-024 resp_X SHALL be the full DATA_WIDTH+1-bit sum, no truncation or wrap; max 4-bit case 15+15 -> 30.
REQ-025 rr_ptr SHALL update only on accept; idle cycles and response stalls SHALL not move it.
REQ-026 A requester deasserting req_valid before accept SHALL simply lose arbitration that cycle; no state change.

Reset
REQ-027 rst high SHALL immediately force state IDLE, rr_ptr 0, adder_A/adder_B 0, resp_X 0, resp_id 0, resp_valid 0, ops_count 0.
REQ-028 rst asserted in ADD or RESP SHALL discard the in-flight operation; no response SHALL be produced after release.
REQ-029 First arbitration after reset release SHALL start from requester 0.

Configuration
REQ-030 Macro ADDER_ARB_STATS_EN defined: ops_count SHALL increment by 1 on each resp_valid&resp_ready edge, saturating at 16'hFFFF.
REQ-031 Macro ADDER_ARB_STATS_EN undefined: ops_count SHALL be constant 0 and no counter register SHALL be synthesized; all other behaviour identical.

Verification
REQ-032 Single op: req_valid=0001, A0=3, B0=5, resp_ready=1 -> req_ready=0001 one cycle, resp_valid 2 edges later, resp_X=8, resp_id=0.
REQ-033 Round robin: all four valid continuously, resp_ready=1 -> grants in order 0,1,2,3,0, each 3 cycles apart.
REQ-034 Overflow width: A=15, B=15 -> resp_X=30 (5'b11110), no wrap.
REQ-035 Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_X, resp_id stable, req_ready=0 throughout; accept resumes one cycle after resp_ready=1 edge.
REQ-036 Reset mid-op: rst pulse while in ADD -> resp_valid stays 0, next request from requester 2 (req_valid=0100) granted, rr_ptr from 0.
REQ-037 Stats: with ADDER_ARB_STATS_EN, 10 completed ops -> ops_count=10; without macro -> ops_count=0.
